datapath_sequencer: RTL

- Multi-cycle control sequencer for the 8-bit microprocessor datapath: bus source mux, ALU operand latches, ALU, register shifter and write-back decoder.
- Accepts one 8-bit instruction per valid/ready handshake and drives the datapath select/enable lines through read, execute and write-back states.
- Sits between the instruction source and the datapath inside the processor top level.

---
 rtl/datapath_pkg.sv | 37 +++
 rtl/sequencer_opdecode.sv | 30 +++
 rtl/datapath_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared states, opcode classes and select codes for datapath_sequencer
package datapath_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_SHIFT,
        CLS_LDK,
        CLS_HALT
    } op_class_t;

    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_LDK  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] MUX_SEL_K0  = 3'd4;
    localparam logic [2:0] MUX_SEL_K1  = 3'd5;
    localparam logic [2:0] MUX_SEL_RES = 3'd6;

    localparam logic [1:0] SHIFT_PASS  = 2'd0;
    localparam logic [1:0] SHIFT_LEFT  = 2'd1;
    localparam logic [1:0] SHIFT_RIGHT = 2'd2;

    function automatic logic [1:0] shift_code(input logic [3:0] opcode);
        return (opcode == OP_SHR) ? SHIFT_RIGHT : SHIFT_LEFT;
    endfunction

endpackage

// File: rtl/sequencer_opdecode.sv
// rtl/sequencer_opdecode.sv - opcode to instruction class and first state after IDLE
module sequencer_opdecode
    import datapath_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class,
    output state_t     idle_next
);

    always_comb begin
        op_class  = CLS_ALU;
        idle_next = S_RD_A;
        case (opcode)
            OP_SHL, OP_SHR: begin
                op_class  = CLS_SHIFT;
                idle_next = S_RD_A;
            end
            OP_LDK: begin
                op_class  = CLS_LDK;
                idle_next = S_WB;
            end
            OP_HALT: begin
                op_class  = CLS_HALT;
                idle_next = S_HALT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle datapath control sequencer; optional DATAPATH_SEQUENCER_RETIRE_COUNT_EN adds retire_count
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter int DATAWIDTH_BUS                  = 8,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int DATAWIDTH_DECODER_SELECTION    = 3
)(
    input  logic                                      datapath_sequencer_CLOCK_50,
    input  logic                                      datapath_sequencer_Reset_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]                  instr,
    input  logic                                      instr_valid,
    output logic                                      instr_ready,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        mux_sel,
    output logic                                      latch_a,
    output logic                                      latch_b,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        alu_sel,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] shifter_sel,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    decoder_sel,
    output logic                                      write_en,
    output logic                                      done,
    output logic                                      halted
`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
    ,
    output logic [15:0]                               retire_count
`endif
);

    state_t                   state;
    logic [DATAWIDTH_BUS-1:0] ir;
    logic [3:0]               ir_op;
    logic [1:0]               ir_dst;
    logic [1:0]               ir_src;
    logic [1:0]               in_dst;
    logic [1:0]               in_src;
    logic [3:0]               dec_opcode;
    op_class_t                op_class;
    state_t                   idle_next;

    assign ir_op  = ir[7:4];
    assign ir_dst = ir[3:2];
    assign ir_src = ir[1:0];
    assign in_dst = instr[3:2];
    assign in_src = instr[1:0];

    // In IDLE the decoder looks at the offered instruction so the first state's outputs can be registered on the transfer edge.
    assign dec_opcode = (state == S_IDLE) ? instr[7:4] : ir_op;

    sequencer_opdecode u_opdecode (
        .opcode    (dec_opcode),
        .op_class  (op_class),
        .idle_next (idle_next)
    );

    assign instr_ready = (state == S_IDLE) && !datapath_sequencer_Reset_InHigh;

    always_ff @(posedge datapath_sequencer_CLOCK_50) begin
        if (datapath_sequencer_Reset_InHigh) begin
            state       <= S_IDLE;
            ir          <= '0;
            mux_sel     <= '0;
            latch_a     <= 1'b0;
            latch_b     <= 1'b0;
            alu_sel     <= '0;
            shifter_sel <= '0;
            decoder_sel <= '0;
            write_en    <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            mux_sel     <= '0;
            latch_a     <= 1'b0;
            latch_b     <= 1'b0;
            alu_sel     <= '0;
            shifter_sel <= '0;
            decoder_sel <= '0;
            write_en    <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= idle_next;
                        case (op_class)
                            CLS_LDK: begin
                                mux_sel     <= in_src[0] ? MUX_SEL_K1 : MUX_SEL_K0;
                                decoder_sel <= DATAWIDTH_DECODER_SELECTION'(in_dst);
                                write_en    <= 1'b1;
                                done        <= 1'b1;
                            end
                            CLS_HALT: begin
                                halted <= 1'b1;
                                done   <= 1'b1;
                            end
                            default: begin
                                mux_sel <= DATAWIDTH_MUX_SELECTION'(in_dst);
                                latch_a <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_A: begin
                    if (op_class == CLS_ALU) begin
                        state   <= S_RD_B;
                        mux_sel <= DATAWIDTH_MUX_SELECTION'(ir_src);
                        latch_b <= 1'b1;
                    end else begin
                        state       <= S_EXEC;
                        shifter_sel <= shift_code(ir_op);
                    end
                end
                S_RD_B: begin
                    state       <= S_EXEC;
                    alu_sel     <= DATAWIDTH_ALU_SELECTION'(ir_op);
                    shifter_sel <= SHIFT_PASS;
                end
                S_EXEC: begin
                    state       <= S_WB;
                    mux_sel     <= MUX_SEL_RES;
                    alu_sel     <= alu_sel;
                    shifter_sel <= shifter_sel;
                    decoder_sel <= DATAWIDTH_DECODER_SELECTION'(ir_dst);
                    write_en    <= 1'b1;
                    done        <= 1'b1;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DATAPATH_SEQUENCER_RETIRE_COUNT_EN
    always_ff @(posedge datapath_sequencer_CLOCK_50) begin
        if (datapath_sequencer_Reset_InHigh) begin
            retire_count <= '0;
        end else if (done) begin
            retire_count <= retire_count + 16'd1;
        end
    end
`endif

endmodule
